cpm_fifo_pack: RTL and testbench

- Synchronous width-converting FIFO for the CPM feed path.
- Accepts narrow words and packs RATIO of them into one wide word, lane 0 in the LSBs, then stores wide words in a DEPTH-entry buffer.
- Output side is first-word-fall-through with a valid/ready handshake.
- Adds partial-word commit with zero padding, almost-full/almost-empty thresholds, and a synchronous flush.

---
 rtl/cpm_fifo_pkg.sv | 29 ++
 rtl/cpm_fifo_pack_lane.sv | 76 +++++++
 rtl/cpm_fifo_pack.sv | 150 +++++++++++++++
 tb/tb_cpm_fifo_pack.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpm_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpm_fifo_pkg
//  Purpose  : Shared helpers for the CPM packing FIFO: ceiling-log2 and the
//             width of a lane-count field able to hold 0..RATIO.
//  Revision : 1.0 - initial release
// ============================================================================
package cpm_fifo_pkg;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

   // A lane count must represent 0..RATIO inclusive.
   function automatic int lane_w(input int ratio);
      return clog2(ratio + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cpm_fifo_pack_lane.sv
`default_nettype none
// ============================================================================
//  Module   : cpm_fifo_pack_lane
//  Purpose  : Narrow-to-wide packer. Holds the partially filled wide word and
//             the lane counter, flags when the offered word would commit, and
//             presents the zero-padded wide word for the commit write.
//  Revision : 1.0 - initial release
// ============================================================================
module cpm_fifo_pack_lane
   import cpm_fifo_pkg::*;
#(
   parameter int IN_WIDTH  = 16,
   parameter int RATIO     = 4,
   parameter int OUT_WIDTH = IN_WIDTH * RATIO,
   parameter int LANE_W    = lane_w(RATIO)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 take,
   input  logic                 in_last,
   input  logic [IN_WIDTH-1:0]  in_data,
   output logic                 would_commit,
   output logic [OUT_WIDTH-1:0] word,
   output logic [LANE_W-1:0]    lanes
);

   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

   logic [LANE_W-1:0] lane_cnt;

   // The offered word closes the wide word if it fills the top lane or is marked last.
   assign would_commit = in_last || (lane_cnt == LAST_LANE);
   assign lanes        = lane_cnt + 1'b1;

   // Lane counter: advances on each non-committing word, restarts on commit or flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_cnt <= '0;
      end else if (flush) begin
         lane_cnt <= '0;
      end else if (take) begin
         if (would_commit) begin
            lane_cnt <= '0;
         end else begin
            lane_cnt <= lane_cnt + 1'b1;
         end
      end
   end

   for (genvar i = 0; i < RATIO; i++) begin : g_lane
      localparam logic [LANE_W-1:0] IDX = LANE_W'(i);
      logic [IN_WIDTH-1:0] held;

      // Capture this lane when it is the current fill position; clear on commit or flush.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            held <= '0;
         end else if (flush) begin
            held <= '0;
         end else if (take) begin
            if (would_commit) begin
               held <= '0;
            end else if (lane_cnt == IDX) begin
               held <= in_data;
            end
         end
      end

      // Current lane takes the live input, lower lanes the held data, upper lanes zero.
      assign word[i*IN_WIDTH +: IN_WIDTH] = (lane_cnt == IDX) ? in_data :
                                            (lane_cnt >  IDX) ? held    : '0;
   end

endmodule
`default_nettype wire

// File: rtl/cpm_fifo_pack.sv
`default_nettype none
// ============================================================================
//  Module   : cpm_fifo_pack
//  Purpose  : Width-converting FWFT FIFO for the CPM feed path. Packs RATIO
//             narrow words (lane 0 in LSBs) into wide entries with a lane
//             count, stores DEPTH entries, and reports count-based flags.
//  Options  : CPM_FIFO_PACK_ERR_EN adds sticky err_ovf / err_udf outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module cpm_fifo_pack
   import cpm_fifo_pkg::*;
#(
   parameter int IN_WIDTH   = 16,
   parameter int RATIO      = 4,
   parameter int OUT_WIDTH  = IN_WIDTH * RATIO,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 1 << ADDR_WIDTH,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_last,
   input  logic [IN_WIDTH-1:0]       in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [OUT_WIDTH-1:0]      out_data,
   output logic [lane_w(RATIO)-1:0]  out_lanes,
   output logic [ADDR_WIDTH:0]       count,
   output logic                      empty,
   output logic                      full,
   output logic                      almost_empty,
   output logic                      almost_full
`ifdef CPM_FIFO_PACK_ERR_EN
   ,
   output logic                      err_ovf,
   output logic                      err_udf
`endif
);

   localparam int LANE_W = lane_w(RATIO);
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH + 1)'(AE_THRESH);

   typedef struct packed {
      logic [LANE_W-1:0]    lanes;
      logic [OUT_WIDTH-1:0] data;
   } entry_t;

   entry_t                mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  would_commit;
   logic                  accept;
   logic                  commit;
   logic                  pop;
   logic [OUT_WIDTH-1:0]  pack_word;
   logic [LANE_W-1:0]     pack_lanes;

   cpm_fifo_pack_lane #(
      .IN_WIDTH  (IN_WIDTH),
      .RATIO     (RATIO),
      .OUT_WIDTH (OUT_WIDTH),
      .LANE_W    (LANE_W)
   ) u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .take         (accept),
      .in_last      (in_last),
      .in_data      (in_data),
      .would_commit (would_commit),
      .word         (pack_word),
      .lanes        (pack_lanes)
   );

   // Flags come from count only; pointers are free-running modulo DEPTH.
   assign empty        = (count == '0);
   assign full         = (count == DEPTH_CNT);
   assign almost_empty = (count <= AE_CNT);
   assign almost_full  = (count >= AF_CNT);

   // Only a committing word needs a free slot; in_ready never looks at out_ready.
   assign in_ready  = !full || !would_commit;
   assign out_valid = !empty;
   assign accept    = in_valid && in_ready && !flush;
   assign commit    = accept && would_commit;
   assign pop       = out_valid && out_ready && !flush;

   assign out_data  = mem[rd_ptr].data;
   assign out_lanes = mem[rd_ptr].lanes;

   // Storage write: contents survive reset and flush, only pointers are cleared.
   always_ff @(posedge clk) begin
      if (commit) begin
         mem[wr_ptr] <= '{lanes: pack_lanes, data: pack_word};
      end
   end

   // Pointer and occupancy tracking; a simultaneous commit and pop leaves count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (commit) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (commit && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !commit) begin
            count <= count - 1'b1;
         end
      end
   end

`ifdef CPM_FIFO_PACK_ERR_EN
   // Sticky error flags for refused pushes and pops against an empty buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_ovf <= 1'b0;
         err_udf <= 1'b0;
      end else if (flush) begin
         err_ovf <= 1'b0;
         err_udf <= 1'b0;
      end else begin
         if (in_valid && !in_ready) begin
            err_ovf <= 1'b1;
         end
         if (out_ready && !out_valid) begin
            err_udf <= 1'b1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpm_fifo_pack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpm_fifo_pack
//  Purpose  : Directed self-checking bench for cpm_fifo_pack with an 8-bit
//             input, RATIO 4 and a 4-entry buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpm_fifo_pack;

   localparam int IN_WIDTH   = 8;
   localparam int RATIO      = 4;
   localparam int OUT_WIDTH  = 32;
   localparam int ADDR_WIDTH = 2;
   localparam int AF_THRESH  = 3;
   localparam int AE_THRESH  = 1;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_last;
   logic [IN_WIDTH-1:0]   in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [OUT_WIDTH-1:0]  out_data;
   logic [2:0]            out_lanes;
   logic [ADDR_WIDTH:0]   count;
   logic                  empty;
   logic                  full;
   logic                  almost_empty;
   logic                  almost_full;
`ifdef CPM_FIFO_PACK_ERR_EN
   logic                  err_ovf;
   logic                  err_udf;
`endif

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_w [4];

   cpm_fifo_pack #(
      .IN_WIDTH   (IN_WIDTH),
      .RATIO      (RATIO),
      .ADDR_WIDTH (ADDR_WIDTH),
      .AF_THRESH  (AF_THRESH),
      .AE_THRESH  (AE_THRESH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_last      (in_last),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_lanes    (out_lanes),
      .count        (count),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full)
`ifdef CPM_FIFO_PACK_ERR_EN
      ,
      .err_ovf      (err_ovf),
      .err_udf      (err_udf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      exp_w[0] = 32'h04030201;
      exp_w[1] = 32'h14131211;
      exp_w[2] = 32'h24232221;
      exp_w[3] = 32'h34333231;

      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #12;
      // reset state
      check("rst_count",     count,        0);
      check("rst_empty",     empty,        1);
      check("rst_full",      full,         0);
      check("rst_ae",        almost_empty, 1);
      check("rst_af",        almost_full,  0);
      check("rst_in_ready",  in_ready,     1);
      check("rst_out_valid", out_valid,    0);
      rst_n = 1'b1;
      tick();

      // full four-lane pack
      push(8'h11, 1'b0);
      push(8'h22, 1'b0);
      push(8'h33, 1'b0);
      check("pack3_out_valid", out_valid, 0);
      push(8'h44, 1'b0);
      check("pack4_out_valid", out_valid, 1);
      check("pack4_data",      out_data,  32'h44332211);
      check("pack4_lanes",     out_lanes, 4);
      check("pack4_count",     count,     1);
      pop_one();
      check("pop1_empty", empty, 1);

      // partial commit with zero padding, next word restarts at lane 0
      push(8'hAA, 1'b0);
      push(8'hBB, 1'b1);
      check("last_data",  out_data,  32'h0000BBAA);
      check("last_lanes", out_lanes, 2);
      check("last_count", count,     1);
      pop_one();
      push(8'hCC, 1'b1);
      check("restart_data",  out_data,  32'h000000CC);
      check("restart_lanes", out_lanes, 1);
      pop_one();
      check("restart_empty", empty, 1);

      // fill the buffer with out_ready low
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 4; i++) begin
            push(8'(16 * k + i + 1), 1'b0);
         end
         if (k == 2) begin
            check("fill3_af",    almost_full, 1);
            check("fill3_full",  full,        0);
            check("fill3_count", count,       3);
         end
      end
      check("fill4_full",     full,        1);
      check("fill4_af",       almost_full, 1);
      check("fill4_count",    count,       4);
      check("fill4_in_ready", in_ready,    1);
      push(8'h41, 1'b0);
      push(8'h42, 1'b0);
      push(8'h43, 1'b0);
      check("full_pack3_count", count, 4);
      in_valid = 1'b1;
      in_data  = 8'h44;
      in_last  = 1'b0;
      #1;
      check("full_commit_in_ready", in_ready, 0);
      tick();
      check("full_hold_count", count, 4);
      check("full_hold_head",  out_data, exp_w[0]);

      // pop frees a slot next cycle, then commit and pop together
      out_ready = 1'b1;
      tick();
      check("popfull_count",    count,    3);
      check("popfull_head",     out_data, exp_w[1]);
      check("popfull_in_ready", in_ready, 1);
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("both_count", count,    3);
      check("both_head",  out_data, exp_w[2]);
      pop_one();
      check("drain1_head",  out_data,     exp_w[3]);
      check("drain1_count", count,        2);
      check("drain1_ae",    almost_empty, 0);
      pop_one();
      check("drain2_head",  out_data,     32'h44434241);
      check("drain2_lanes", out_lanes,    4);
      check("drain2_ae",    almost_empty, 1);
      pop_one();
      check("drain3_empty", empty, 1);
      pop_one();
      check("idle_pop_count", count, 0);

      // flush mid-pack with two stored words
      for (int i = 0; i < 4; i++) push(8'h51 + 8'(i), 1'b0);
      for (int i = 0; i < 4; i++) push(8'h61 + 8'(i), 1'b0);
      push(8'h71, 1'b0);
      push(8'h72, 1'b0);
      check("preflush_count", count, 2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_count",     count,     0);
      check("flush_empty",     empty,     1);
      check("flush_out_valid", out_valid, 0);
      push(8'hA1, 1'b0);
      push(8'hA2, 1'b0);
      push(8'hA3, 1'b0);
      check("postflush3_out_valid", out_valid, 0);
      push(8'hA4, 1'b0);
      check("postflush_data",  out_data,  32'hA4A3A2A1);
      check("postflush_lanes", out_lanes, 4);
      check("postflush_count", count,     1);

      // asynchronous reset in the middle of a pack
      push(8'hB1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_count",     count,     0);
      check("arst_in_ready",  in_ready,  1);
      check("arst_out_valid", out_valid, 0);
      #2;
      rst_n = 1'b1;
      tick();
      push(8'hC5, 1'b1);
      check("postrst_data",  out_data,  32'h000000C5);
      check("postrst_lanes", out_lanes, 1);
      pop_one();
      check("postrst_empty", empty, 1);

`ifdef CPM_FIFO_PACK_ERR_EN
      check("err_udf_clear", err_udf, 0);
      pop_one();
      check("err_udf_set", err_udf, 1);
      tick();
      check("err_udf_sticky", err_udf, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("err_udf_flushed", err_udf, 0);
      check("err_ovf_clear",   err_ovf, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
